// File: rtl/admo_alu_arbiter_pkg.sv
// Shared widths, ALU opcode encodings and arbiter FSM states
// for the ALU sharing arbiter.
package admo_alu_arbiter_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ALU_OPW    = 4;

  typedef enum logic [ALU_OPW-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4
  } alu_op_e;

  typedef enum logic [0:0] {
    ALUARB_IDLE = 1'b0,
    ALUARB_EXEC = 1'b1
  } aluarb_state_e;

endpackage

// File: rtl/admo_alu_arbiter_if.sv
// Request/response bundle for both ALU requester ports.
// The core side uses master, the arbiter uses slave.
interface admo_alu_arbiter_if
  import admo_alu_arbiter_pkg::*;
#(
  parameter int DW  = DATA_WIDTH,
  parameter int OPW = ALU_OPW
);

  logic           req0_valid;
  logic           req0_ready;
  logic [DW-1:0]  req0_a;
  logic [DW-1:0]  req0_b;
  logic [OPW-1:0] req0_op;
  logic           rsp0_valid;
  logic           rsp0_ready;
  logic [DW-1:0]  rsp0_res;

  logic           req1_valid;
  logic           req1_ready;
  logic [DW-1:0]  req1_a;
  logic [DW-1:0]  req1_b;
  logic [OPW-1:0] req1_op;
  logic           rsp1_valid;
  logic           rsp1_ready;
  logic [DW-1:0]  rsp1_res;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op, rsp0_ready,
    output req1_valid, req1_a, req1_b, req1_op, rsp1_ready,
    input  req0_ready, rsp0_valid, rsp0_res,
    input  req1_ready, rsp1_valid, rsp1_res
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op, rsp0_ready,
    input  req1_valid, req1_a, req1_b, req1_op, rsp1_ready,
    output req0_ready, rsp0_valid, rsp0_res,
    output req1_ready, rsp1_valid, rsp1_res
  );

endinterface

// File: rtl/admo_rr_arb2.sv
// Two-way round-robin arbiter; prio names the port that
// wins when both are eligible.
module admo_rr_arb2 (
  input  logic [1:0] elig,
  input  logic       prio,
  output logic       grant,
  output logic       gnt_valid
);

  assign gnt_valid = |elig;
  assign grant     = (&elig) ? prio : elig[1];

endmodule

// File: rtl/admo_alu_arbiter.sv
// Shares one combinational ALU between the execute stage and
// load/store address generation with round-robin arbitration.
module admo_alu_arbiter
  import admo_alu_arbiter_pkg::*;
#(
  parameter int DW  = DATA_WIDTH,
  parameter int OPW = ALU_OPW
) (
  input  logic            clk,
  input  logic            rst,
  admo_alu_arbiter_if.slave bus,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  output logic [OPW-1:0]  alu_op,
  input  logic [DW-1:0]   alu_res
);

  aluarb_state_e  state_q, state_d;
  logic           prio_q, prio_d;
  logic           owner_q, owner_d;
  logic [DW-1:0]  a_q, a_d;
  logic [DW-1:0]  b_q, b_d;
  logic [OPW-1:0] op_q, op_d;
  logic [1:0]     rv_q, rv_d;
  logic [DW-1:0]  r0_q, r0_d;
  logic [DW-1:0]  r1_q, r1_d;

  logic [1:0] elig;
  logic       grant;
  logic       gnt_valid;

  // An occupied response register blocks its port even if it
  // is being drained this cycle.
  assign elig = (state_q == ALUARB_IDLE)
    ? {bus.req1_valid & ~rv_q[1], bus.req0_valid & ~rv_q[0]}
    : 2'b00;

  admo_rr_arb2 u_arb (
    .elig      (elig),
    .prio      (prio_q),
    .grant     (grant),
    .gnt_valid (gnt_valid)
  );

  assign bus.req0_ready = elig[0] & gnt_valid & ~grant;
  assign bus.req1_ready = elig[1] & gnt_valid & grant;

  assign bus.rsp0_valid = rv_q[0];
  assign bus.rsp1_valid = rv_q[1];
  assign bus.rsp0_res   = r0_q;
  assign bus.rsp1_res   = r1_q;

  assign alu_a  = a_q;
  assign alu_b  = b_q;
  assign alu_op = op_q;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    r0_d    = r0_q;
    r1_d    = r1_q;
    rv_d[0] = rv_q[0] & ~bus.rsp0_ready;
    rv_d[1] = rv_q[1] & ~bus.rsp1_ready;
    unique case (state_q)
      ALUARB_IDLE: begin
        if (gnt_valid) begin
          owner_d = grant;
          prio_d  = ~grant;
          state_d = ALUARB_EXEC;
          a_d     = grant ? bus.req1_a  : bus.req0_a;
          b_d     = grant ? bus.req1_b  : bus.req0_b;
          op_d    = grant ? bus.req1_op : bus.req0_op;
        end
      end
      ALUARB_EXEC: begin
        state_d = ALUARB_IDLE;
        if (owner_q) begin
          rv_d[1] = 1'b1;
          r1_d    = alu_res;
        end else begin
          rv_d[0] = 1'b1;
          r0_d    = alu_res;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ALUARB_IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      rv_q    <= 2'b00;
      r0_q    <= '0;
      r1_q    <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      rv_q    <= rv_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
    end
  end

endmodule

// File: tb/tb_admo_alu_arbiter.sv
// Directed and randomized checks of the ALU arbiter against a
// transaction-level reference model.
module tb_admo_alu_arbiter;

  localparam int DW  = 32;
  localparam int OPW = 4;

  logic clk;
  logic rst;
  logic [DW-1:0]  alu_a;
  logic [DW-1:0]  alu_b;
  logic [OPW-1:0] alu_op;
  logic [DW-1:0]  alu_res;

  int n_chk  = 0;
  int n_fail = 0;

  admo_alu_arbiter_if #(.DW(DW), .OPW(OPW)) bus ();

  admo_alu_arbiter #(.DW(DW), .OPW(OPW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_op  (alu_op),
    .alu_res (alu_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ref_alu(
    input logic [DW-1:0] a, input logic [DW-1:0] b,
    input logic [OPW-1:0] op);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      default: return '0;
    endcase
  endfunction

  assign alu_res = ref_alu(alu_a, alu_b, alu_op);

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: at most one operation in flight, one
  // result slot per port, tie goes to m_prio.
  bit          m_busy;
  bit          m_port;
  logic [DW-1:0] m_res;
  bit          m_rv [2];
  logic [DW-1:0] m_rres [2];
  bit          m_prio;
  logic [DW-1:0] m_a, m_b;
  logic [OPW-1:0] m_op;

  task automatic model_reset();
    m_busy = 0; m_port = 0; m_res = '0; m_prio = 0;
    m_rv[0] = 0; m_rv[1] = 0;
    m_rres[0] = '0; m_rres[1] = '0;
    m_a = '0; m_b = '0; m_op = '0;
  endtask

  task automatic drive(
    input bit v0, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
    input logic [OPW-1:0] o0, input bit r0,
    input bit v1, input logic [DW-1:0] a1, input logic [DW-1:0] b1,
    input logic [OPW-1:0] o1, input bit r1);
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req0_op = o0; bus.rsp0_ready = r0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1;
    bus.req1_op = o1; bus.rsp1_ready = r1;
  endtask

  // Called just after a negedge with inputs set; checks, then
  // advances the model across the next rising edge.
  task automatic tick();
    bit e0, e1, g0, g1;
    #1;
    e0 = !m_busy && bus.req0_valid && !m_rv[0];
    e1 = !m_busy && bus.req1_valid && !m_rv[1];
    g0 = e0 && (!e1 || m_prio == 1'b0);
    g1 = e1 && (!e0 || m_prio == 1'b1);
    check("req0_ready", 64'(bus.req0_ready), 64'(g0));
    check("req1_ready", 64'(bus.req1_ready), 64'(g1));
    check("rsp0_valid", 64'(bus.rsp0_valid), 64'(m_rv[0]));
    check("rsp1_valid", 64'(bus.rsp1_valid), 64'(m_rv[1]));
    check("rsp0_res", 64'(bus.rsp0_res), 64'(m_rres[0]));
    check("rsp1_res", 64'(bus.rsp1_res), 64'(m_rres[1]));
    check("alu_a", 64'(alu_a), 64'(m_a));
    check("alu_b", 64'(alu_b), 64'(m_b));
    check("alu_op", 64'(alu_op), 64'(m_op));
    if (rst) begin
      model_reset();
    end else begin
      if (m_rv[0] && bus.rsp0_ready) m_rv[0] = 0;
      if (m_rv[1] && bus.rsp1_ready) m_rv[1] = 0;
      if (m_busy) begin
        m_rv[m_port] = 1;
        m_rres[m_port] = m_res;
        m_busy = 0;
      end else if (g0) begin
        m_busy = 1; m_port = 0; m_prio = 1;
        m_a = bus.req0_a; m_b = bus.req0_b; m_op = bus.req0_op;
        m_res = ref_alu(m_a, m_b, m_op);
      end else if (g1) begin
        m_busy = 1; m_port = 1; m_prio = 0;
        m_a = bus.req1_a; m_b = bus.req1_b; m_op = bus.req1_op;
        m_res = ref_alu(m_a, m_b, m_op);
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    rst = 1;
    tick();
    rst = 0;
  endtask

  initial begin
    rst = 1;
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 0;

    // Single op: 5+7, latency two cycles
    drive(1, 5, 7, 0, 1, 0, 0, 0, 0, 1);
    #1 check("t1_accept", 64'(bus.req0_ready), 64'd1);
    tick();
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    tick();
    #1 check("t1_valid", 64'(bus.rsp0_valid), 64'd1);
    check("t1_res", 64'(bus.rsp0_res), 64'd12);
    tick();
    #1 check("t1_drain", 64'(bus.rsp0_valid), 64'd0);
    tick();

    // Both ports requesting back-to-back; port 0 first
    do_reset();
    drive(1, 1, 1, 0, 1, 1, 10, 20, 0, 1);
    #1 check("rr_first0", 64'(bus.req0_ready), 64'd1);
    check("rr_first1", 64'(bus.req1_ready), 64'd0);
    for (int i = 0; i < 12; i++) tick();
    check("rr_res0", 64'(bus.rsp0_res), 64'd2);
    check("rr_res1", 64'(bus.rsp1_res), 64'd30);

    // Stalled port 0 does not block port 1; no bypass
    do_reset();
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 1);
    tick();
    tick();
    drive(1, 1, 1, 0, 0, 1, 3, 4, 0, 1);
    #1 check("stall_r0", 64'(bus.req0_ready), 64'd0);
    check("stall_r1", 64'(bus.req1_ready), 64'd1);
    tick();
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 1);
    tick();
    #1 check("stall_res1", 64'(bus.rsp1_res), 64'd7);
    check("stall_blk0", 64'(bus.req0_ready), 64'd0);
    tick();
    drive(1, 9, 9, 0, 1, 0, 0, 0, 0, 1);
    #1 check("nobypass", 64'(bus.req0_ready), 64'd0);
    tick();
    #1 check("resume0", 64'(bus.req0_ready), 64'd1);
    tick();
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    tick();
    tick();

    // Reset during EXEC drops the op
    do_reset();
    drive(0, 0, 0, 0, 1, 1, 100, 1, 0, 1);
    tick();
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    rst = 1;
    tick();
    rst = 0;
    #1 check("rstx_valid", 64'(bus.rsp1_valid), 64'd0);
    check("rstx_alu_a", 64'(alu_a), 64'd0);
    tick();
    drive(0, 0, 0, 0, 1, 1, 2, 3, 0, 1);
    tick();
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    tick();
    #1 check("rstx_res", 64'(bus.rsp1_res), 64'd5);
    tick();

    // Wrap-around
    drive(1, 32'hFFFF_FFFF, 1, 0, 1, 0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    tick();
    #1 check("wrap_valid", 64'(bus.rsp0_valid), 64'd1);
    check("wrap_res", 64'(bus.rsp0_res), 64'd0);
    tick();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, $urandom,
            4'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom, $urandom,
            4'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
      rst = ($urandom_range(0, 63) == 0);
      tick();
    end
    rst = 0;
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/admo_alu_arbiter.md
Name: admo_alu_arbiter

Overview:
- Shares the single combinational ALU (admo_alu) between two requesters: port 0 (execute stage) and port 1 (load/store address generation).
- Arbitrates round-robin, latches the winner's operands into an issue register, drives the ALU from that register, and captures the result into a per-port response register with valid/ready handshake.
- Sits between the core pipeline and admo_alu; all ALU accesses go through it.

Parameters:
- DW, `DATA_WIDTH, operand/result width.
- OPW, 4, ALU opcode width; must equal admo_alu alu_op width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- req0_valid  in  1  port 0 request valid.
- req0_ready  out  1  port 0 request accepted this cycle when valid&ready.
- req0_a  in  DW  port 0 operand A.
- req0_b  in  DW  port 0 operand B.
- req0_op  in  OPW  port 0 ALU op.
- rsp0_valid  out  1  port 0 result valid.
- rsp0_ready  in  1  port 0 result consumed when valid&ready.
- rsp0_res  out  DW  port 0 result.
- req1_valid, req1_ready, req1_a, req1_b, req1_op, rsp1_valid, rsp1_ready, rsp1_res: same as port 0, for port 1.
- alu_a  out  DW  to admo_alu alu_a.
- alu_b  out  DW  to admo_alu alu_b.
- alu_op  out  OPW  to admo_alu alu_op.
- alu_res  in  DW  from admo_alu alu_res.

Behaviour:
- Clocking: one clock, clk; reset rst is synchronous, active-high.
- Reset values: state=IDLE, prio=0, rsp0_valid=rsp1_valid=0, rsp0_res=rsp1_res=0, issue regs (alu_a/alu_b/alu_op/owner)=0. Outputs alu_a/alu_b/alu_op come straight from the issue regs, so they are 0 after reset.
- FSM states:
  - IDLE: arbitrate.
  - EXEC: issue regs drive the ALU.
- Eligibility: eligN = reqN_valid & ~rspN_valid & (state==IDLE). No bypass: a port whose response register is occupied is ineligible even if rspN_ready=1 in the same cycle.
- Grant (IDLE only):
  - Both eligible: port==prio wins.
  - One eligible: it wins.
  - reqN_ready = eligN & (grant==N). Combinational from valid is allowed.
- On grant:
  - Latch reqN_a/b/op into the issue regs and set owner=N.
  - Set prio=~N.
  - Go to EXEC.
  - No grant: stay in IDLE, prio unchanged.
- EXEC (always one cycle): rsp[owner]_res<=alu_res, rsp[owner]_valid<=1, go to IDLE. Both req ready=0 during EXEC.
- Response: rspN_valid clears on rspN_valid&rspN_ready. rspN_res holds its value until overwritten by the next completion.
- Latency: accept at cycle N, rspN_valid=1 at cycle N+2. Peak throughput is one op per 2 cycles.
- Stall behaviour: an unconsumed response blocks only its own port; the other port continues to be served.
- Simultaneous events:
  - A response consumed in the same cycle as an EXEC completion to the other port: both take effect.
  - Completion to port N cannot coincide with rspN_valid=1, because eligibility prevents it.
- Reset mid-EXEC: the in-flight op is dropped and no response is produced.
- Width rule: the result is DW bits, taken unchanged from alu_res. No carry/overflow is exported.

Decomposition:
- Shared package / admo_macros.v: DATA_WIDTH, ALU opcode width and opcode encodings, and the FSM state encodings (ALUARB_IDLE, ALUARB_EXEC).
- Sub-module admo_rr_arb2: 2-way round-robin arbiter (inputs elig[1:0], prio; outputs grant, gnt_valid). It is reused later for memory-port sharing.
- Response registers are written inline; no separate sub-module.

Test Plan:
- Reset, then port 0 issues a=5, b=7, op=0 with rsp0_ready=1 -> req0_ready=1 at cycle T; rsp0_valid=1, rsp0_res=12 at T+2; rsp0_valid=0 at T+3.
- Both ports valid every cycle (p0: 1+1; p1: 10+20), responses always ready -> grants alternate 0,1,0,1; results 2 and 30 delivered alternately every 2 cycles; prio starts at 0.
- Port 0 result pending with rsp0_ready=0 and port 0 still requesting; port 1 issues 3+4 -> req0_ready stays 0; port 1 receives 7; port 0 resumes only after its response is consumed.
- rsp0_ready asserted in the same cycle as a new req0_valid -> no accept in that cycle; accept on the next cycle.
- rst asserted during EXEC of p1 100+1 -> no rsp1_valid; all outputs 0 on the next cycle; the first request after reset is served with the original latency.
- Wrap-around: port 0 issues 0xFFFFFFFF+1 (DW=32) -> rsp0_res=0.
